// File: rtl/read_controller_if.sv
// Bundle between the read controller and its UART RX/TX and BRAM neighbours.
// rx_data_ready is a one-cycle valid pulse with no back-pressure; tx_start is a request that may only be raised while tx_busy is low.
interface read_controller_if;
  logic [7:0] byte_received;
  logic       rx_data_ready;
  logic       tx_busy;
  logic [7:0] dout;
  logic       en;
  logic [9:0] addr;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic [2:0] status;

  modport master (
    input  byte_received, rx_data_ready, tx_busy, dout,
    output en, addr, tx_start, tx_data, busy, done, status
  );

  modport slave (
    output byte_received, rx_data_ready, tx_busy, dout,
    input  en, addr, tx_start, tx_data, busy, done, status
  );
endinterface

// File: rtl/read_controller.sv
// Waits for the ASCII command "r",MEM,LF on the UART and then streams all 1024 BRAM bytes
// out over UART TX, one byte per FETCH/LATCH/SEND/GUARD pass.
module read_controller #(
    parameter logic [7:0] MEM = "a"
) (
    input logic          clk,
    input logic          rst,
    read_controller_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        GUARD = 3'd4
    } state_t;

    localparam logic [23:0] CMD_READ = {8'h72, MEM, 8'h0A};
    localparam logic [9:0]  LAST_ADDR = 10'd1023;

    state_t      state;
    state_t      state_nxt;
    logic        rx_r;
    logic [23:0] cmd;
    logic [9:0]  addr_q;
    logic [7:0]  tx_data_q;
    logic        cmd_match;

    assign cmd_match = (cmd == CMD_READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = cmd_match ? FETCH : IDLE;
            FETCH:   state_nxt = LATCH;
            LATCH:   state_nxt = SEND;
            SEND:    state_nxt = bus.tx_busy ? SEND : GUARD;
            GUARD:   state_nxt = (addr_q == LAST_ADDR) ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // The match clears cmd on the edge that leaves IDLE, so a stale command
    // cannot retrigger once the dump returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_r      <= 1'b0;
            cmd       <= 24'd0;
            addr_q    <= 10'd0;
            tx_data_q <= 8'd0;
        end else begin
            rx_r <= bus.rx_data_ready;
            if (state == IDLE) begin
                if (cmd_match) begin
                    cmd <= 24'd0;
                end else if (rx_r) begin
                    cmd <= {cmd[15:0], bus.byte_received};
                end
            end
            if (state == LATCH) begin
                tx_data_q <= bus.dout;
            end
            if (state == GUARD) begin
                addr_q <= (addr_q == LAST_ADDR) ? 10'd0 : addr_q + 10'd1;
            end
        end
    end

    always_comb begin
        bus.en       = (state == FETCH);
        bus.tx_start = (state == SEND) && !bus.tx_busy;
        bus.done     = (state == GUARD) && (addr_q == LAST_ADDR);
        bus.busy     = (state != IDLE);
        bus.status   = state;
        bus.addr     = addr_q;
        bus.tx_data  = tx_data_q;
    end

endmodule

// File: doc/read_controller.md
READ_CONTROLLER -- requirements
Module: read_controller

Interface
REQ-001 Parameter MEM, default "a", 8-bit ASCII memory identifier matched in the read command.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 byte_received  input  8  UART RX byte; held stable by the receiver until the next byte.
REQ-005 rx_data_ready  input  1  one-cycle pulse, byte_received valid.
REQ-006 tx_busy  input  1  UART TX busy; tx_start is accepted only while low.
REQ-007 dout  input  8  BRAM read data, valid one cycle after en is high.
REQ-008 en  output  1  BRAM enable, read-only; no write enable exists.
REQ-009 addr  output  10  BRAM read address.
REQ-010 tx_start  output  1  one-cycle request to transmit tx_data.
REQ-011 tx_data  output  8  byte to transmit; registered.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse on completion of a 1024-byte dump.
REQ-014 status  output  3  current state encoding.

Function
REQ-015 rx_data_ready SHALL be registered once (rx_r); the 24-bit command register SHALL shift {cmd[15:0],byte_received} on cycles where rx_r=1 and state=IDLE.
REQ-016 The command register SHALL NOT shift outside IDLE; bytes received during a dump are discarded.
REQ-017 States SHALL be IDLE=0, FETCH=1, LATCH=2, SEND=3, GUARD=4; encodings 5-7 SHALL return to IDLE.
REQ-018 IDLE: when cmd=={"r",MEM,8'h0A}, go to FETCH next edge and clear cmd to 0 on that same edge (no retrigger).
REQ-019 FETCH: en=1 with current addr; go to LATCH.
REQ-020 LATCH: tx_data <= dout; go to SEND.
REQ-021 SEND: if tx_busy=0, assert tx_start=1 for this cycle and go to GUARD; otherwise stay in SEND with tx_start=0.
REQ-022 GUARD: one cycle; tx_start=0; if addr==1023, go to IDLE, set addr to 0, and pulse done; else addr <= addr+1 and go to FETCH.
REQ-023 addr SHALL change only in GUARD or on reset; it SHALL never pass 1023, and the wrap to 0 occurs only at completion.
REQ-024 tx_data SHALL hold its value from LATCH until the next LATCH.
REQ-025 The first en SHALL occur in the cycle after the 3rd rising edge following the cycle in which rx_data_ready is high with 8'h0A completing a match.
REQ-026 Per-byte period SHALL be exactly 4 cycles when tx_busy stays low; a full dump therefore produces 1024 tx_start pulses.
REQ-027 en, tx_start and done SHALL each be high only in the states defined above and low everywhere else.
REQ-028 Non-matching commands (wrong letter, wrong MEM, missing 8'h0A) SHALL leave the block in IDLE with en=0.

Reset
REQ-029 On rst: state=IDLE, addr=0, tx_data=0, cmd=0, rx_r=0, and outputs en, tx_start, done, busy=0, status=0, all at the next edge.
REQ-030 rst mid-dump SHALL abort the dump without emitting further tx_start; a subsequent command SHALL restart at addr 0.
REQ-031 rst SHALL take priority over every state transition and over the command match.

Verification
REQ-032 Preload BRAM[i]=i[7:0], tie tx_busy=0, send "r","a",0x0A -> 1024 tx_start pulses with tx_data 0x00..0xFF repeating, 4 cycles apart, one done, and busy low afterward.
REQ-033 With MEM="a", send "w","a",0x0A, then "r","b",0x0A -> en, tx_start and busy stay 0.
REQ-034 Hold tx_busy=1 for 50 cycles while in SEND -> tx_start=0, addr unchanged, status=3; release -> exactly one tx_start pulse.
REQ-035 Assert rst at byte 500 -> all outputs reach reset values at the next edge; a new command dumps from addr 0 and yields 1024 bytes.
REQ-036 Inject "r","a",0x0A during a dump -> exactly 1024 bytes total and no second dump after done.
REQ-037 Check latency: first en on the 3rd edge after the 0x0A pulse; addr=1023 in the final GUARD, then addr=0 in IDLE.
